// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with one-word lines between the IF
// stage and the byte-serial memory controller; misses refill one word.
module inst_cache #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 16 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_resp,
  output logic [31:0] if_inst,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];
  logic                  resp_q;
  logic                  drop;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  req_io, fill_io, hit;
  logic                  unused_addr_bits;

  assign req_idx  = if_addr[2+INDEX_BITS-1:2];
  assign req_tag  = if_addr[17:2+INDEX_BITS];
  assign req_io   = (if_addr[17:16] == 2'b11);
  assign fill_idx = mc_addr[2+INDEX_BITS-1:2];
  assign fill_tag = mc_addr[17:2+INDEX_BITS];
  assign fill_io  = (mc_addr[17:16] == 2'b11);
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !req_io;

  assign unused_addr_bits = ^{if_addr[1:0], mc_addr[1:0], mc_addr[31:18]};

  // The registered pulse is held through a stall and only shown while rdy is
  // high; a flush in the response cycle drops it.
  assign if_resp = resp_q & rdy & ~if_cancel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid   <= '0;
      resp_q  <= 1'b0;
      drop    <= 1'b0;
      if_inst <= '0;
      mc_req  <= 1'b0;
      mc_addr <= '0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (resp_q) begin
            resp_q <= 1'b0;
          end else if (if_req && !if_cancel) begin
            if (hit) begin
              resp_q  <= 1'b1;
              if_inst <= data_mem[req_idx];
            end else begin
              mc_req  <= 1'b1;
              mc_addr <= {if_addr[31:2], 2'b00};
              drop    <= 1'b0;
              state   <= REFILL;
            end
          end
        end
        REFILL: begin
          if (if_cancel) drop <= 1'b1;
          if (mc_done) begin
            // The bus transaction cannot be aborted, so a cancelled refill
            // still allocates the line.
            if (!fill_io) begin
              valid[fill_idx]    <= 1'b1;
              tag_mem[fill_idx]  <= fill_tag;
              data_mem[fill_idx] <= mc_data;
            end
            if_inst <= mc_data;
            resp_q  <= !(drop || if_cancel);
            mc_req  <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          resp_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a cycle table of inputs and expected outputs
// followed by a bounded miss/hit sequence.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst, rdy, if_req, if_cancel, mc_done;
  logic [31:0] if_addr, mc_data;
  logic        if_resp, mc_req;
  logic [31:0] if_inst, mc_addr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  inst_cache #(.INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_resp(if_resp), .if_inst(if_inst),
    .mc_req(mc_req), .mc_addr(mc_addr),
    .mc_done(mc_done), .mc_data(mc_data)
  );

  always #5 clk = ~clk;

  // One row = one clock cycle: inputs driven during it, outputs seen during it.
  typedef struct {
    logic        rst, rdy, req;
    logic [31:0] addr;
    logic        can, done;
    logic [31:0] data;
    logic        chk;
    logic        e_resp;
    logic [31:0] e_inst;
    logic        chk_inst;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic y, input logic q, input logic [31:0] a,
                     input logic c, input logic d, input logic [31:0] dat,
                     input logic ck, input logic er, input logic [31:0] ei, input logic ci,
                     input logic eq, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rdy = y; v.req = q; v.addr = a; v.can = c; v.done = d; v.data = dat;
    v.chk = ck; v.e_resp = er; v.e_inst = ei; v.chk_inst = ci; v.e_req = eq; v.e_addr = ea;
    vecs.push_back(v);
  endtask

  task automatic idle_in();
    rst = 1'b0; rdy = 1'b1; if_req = 1'b0; if_addr = '0;
    if_cancel = 1'b0; mc_done = 1'b0; mc_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic saw_req;
    idle_in();
    rst = 1'b1;

    //   rst rdy req addr          can done data          chk resp inst         ci  req addr
    add(1, 1, 0, 32'h0,         0, 0, 32'h0,         0,  0, 32'h0,         0,  0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         1,  0, 32'h0);
    // cold miss on 0x0
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h0);
    add(0, 1, 1, 32'h0,         0, 1, 32'h00000513,  1,  0, 32'h0,         0,  1, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  1, 32'h00000513,  1,  0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    // hit on 0x0
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  1, 32'h00000513,  1,  0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    // conflict eviction on index 1
    add(0, 1, 1, 32'h4,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    add(0, 1, 1, 32'h4,         0, 1, 32'hAAAAAAAA,  1,  0, 32'h0,         0,  1, 32'h4);
    add(0, 1, 1, 32'h4,         0, 0, 32'h0,         1,  1, 32'hAAAAAAAA,  1,  0, 32'h4);
    add(0, 1, 1, 32'h104,       0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h4);
    add(0, 1, 1, 32'h104,       0, 1, 32'hBBBBBBBB,  1,  0, 32'h0,         0,  1, 32'h104);
    add(0, 1, 1, 32'h104,       0, 0, 32'h0,         1,  1, 32'hBBBBBBBB,  1,  0, 32'h104);
    add(0, 1, 1, 32'h4,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h104);
    add(0, 1, 1, 32'h4,         0, 1, 32'hAAAAAAAA,  1,  0, 32'h0,         0,  1, 32'h4);
    add(0, 1, 1, 32'h4,         0, 0, 32'h0,         1,  1, 32'hAAAAAAAA,  1,  0, 32'h4);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h4);
    // cancel one cycle into refill of 0x1000
    add(0, 1, 1, 32'h1000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h4);
    add(0, 1, 1, 32'h1000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h1000);
    add(0, 1, 1, 32'h1000,      1, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h1000);
    add(0, 1, 0, 32'h0,         0, 1, 32'h12345678,  1,  0, 32'h0,         0,  1, 32'h1000);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h1000);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h1000);
    add(0, 1, 1, 32'h1000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h1000);
    add(0, 1, 1, 32'h1000,      0, 0, 32'h0,         1,  1, 32'h12345678,  1,  0, 32'h1000);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h1000);
    // rdy stall during refill and during the pending response
    add(0, 1, 1, 32'h2000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h1000);
    add(0, 0, 1, 32'h2000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h2000);
    add(0, 0, 1, 32'h2000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h2000);
    add(0, 0, 1, 32'h2000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h2000);
    add(0, 0, 1, 32'h2000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h2000);
    add(0, 0, 1, 32'h2000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h2000);
    add(0, 1, 1, 32'h2000,      0, 1, 32'hCAFEF00D,  1,  0, 32'h0,         0,  1, 32'h2000);
    add(0, 0, 1, 32'h2000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h2000);
    add(0, 0, 1, 32'h2000,      0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h2000);
    add(0, 1, 1, 32'h2000,      0, 0, 32'h0,         1,  1, 32'hCAFEF00D,  1,  0, 32'h2000);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h2000);
    // I/O space: two fetches both refill, then reset during the second refill
    add(0, 1, 1, 32'h30000,     0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h2000);
    add(0, 1, 1, 32'h30000,     0, 1, 32'h11111111,  1,  0, 32'h0,         0,  1, 32'h30000);
    add(0, 1, 1, 32'h30000,     0, 0, 32'h0,         1,  1, 32'h11111111,  1,  0, 32'h30000);
    add(0, 1, 1, 32'h30000,     0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h30000);
    add(1, 1, 1, 32'h30000,     0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h30000);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         1,  0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 1, 32'h77777777,  1,  0, 32'h0,         1,  0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         1,  0, 32'h0);
    // after reset 0x0 misses again
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  1, 32'h0);
    add(0, 1, 1, 32'h0,         0, 1, 32'h00000513,  1,  0, 32'h0,         0,  1, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  1, 32'h00000513,  1,  0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    // cancel in IDLE suppresses a hit; the re-presented request hits
    add(0, 1, 1, 32'h0,         1, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);
    add(0, 1, 1, 32'h0,         0, 0, 32'h0,         1,  1, 32'h00000513,  1,  0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1,  0, 32'h0,         0,  0, 32'h0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      rst = vecs[i].rst; rdy = vecs[i].rdy; if_req = vecs[i].req; if_addr = vecs[i].addr;
      if_cancel = vecs[i].can; mc_done = vecs[i].done; mc_data = vecs[i].data;
      @(negedge clk);
      if (vecs[i].chk) begin
        n_vec++;
        if (if_resp !== vecs[i].e_resp) begin
          n_err++;
          $display("FAIL row%0d if_resp: got %b want %b", i, if_resp, vecs[i].e_resp);
        end
        if (vecs[i].chk_inst && if_inst !== vecs[i].e_inst) begin
          n_err++;
          $display("FAIL row%0d if_inst: got %h want %h", i, if_inst, vecs[i].e_inst);
        end
        if (mc_req !== vecs[i].e_req) begin
          n_err++;
          $display("FAIL row%0d mc_req: got %b want %b", i, mc_req, vecs[i].e_req);
        end
        if (mc_addr !== vecs[i].e_addr) begin
          n_err++;
          $display("FAIL row%0d mc_addr: got %h want %h", i, mc_addr, vecs[i].e_addr);
        end
      end
    end

    // Bounded miss then hit on 0x40 (index 16)
    @(posedge clk); #1;
    idle_in();
    if_req = 1'b1; if_addr = 32'h40;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!mc_req && cyc < 10);
    n_vec++;
    if (mc_req !== 1'b1 || mc_addr !== 32'h40) begin
      n_err++;
      $display("FAIL seq_miss_req: got req=%b addr=%h want req=1 addr=00000040", mc_req, mc_addr);
    end
    @(posedge clk); #1;
    mc_done = 1'b1; mc_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    mc_done = 1'b0; mc_data = '0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!if_resp && cyc < 5);
    n_vec++;
    if (if_resp !== 1'b1 || if_inst !== 32'hDEADBEEF || cyc != 1) begin
      n_err++;
      $display("FAIL seq_miss_resp: got resp=%b inst=%h after %0d want resp=1 inst=deadbeef after 1",
               if_resp, if_inst, cyc);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(posedge clk); #1;
    if_req = 1'b1;
    saw_req = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; saw_req |= mc_req; end while (!if_resp && cyc < 6);
    n_vec++;
    if (if_resp !== 1'b1 || if_inst !== 32'hDEADBEEF || cyc != 2 || saw_req) begin
      n_err++;
      $display("FAIL seq_hit: got resp=%b inst=%h after %0d mc_req_seen=%b want resp=1 inst=deadbeef after 2 mc_req_seen=0",
               if_resp, if_inst, cyc, saw_req);
    end
    @(posedge clk); #1;
    if_req = 1'b0;
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
